// File: rtl/conv_window_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : conv_window_sequencer
// Description : Nested address scheduler for a valid, stride-1 convolution.
//               Walks every output pixel and, per pixel, every kernel tap in
//               raster order, emitting one feature-map read address per cycle
//               with window-first / window-last framing markers.
//               Optional feature macro: CONV_SEQ_STALL_EN (adds i_stall).
// Revision    : 1.0 - initial release
// ============================================================================
module conv_window_sequencer #(
   parameter int IN_W   = 32,
   parameter int K      = 5,
   parameter int CNT_W  = 6,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              global_rst_n,
   input  logic              i_start,
`ifdef CONV_SEQ_STALL_EN
   input  logic              i_stall,
`endif
   output logic              o_busy,
   output logic [ADDR_W-1:0] o_rd_addr,
   output logic              o_rd_valid,
   output logic              o_win_first,
   output logic              o_win_last,
   output logic [CNT_W-1:0]  o_out_row,
   output logic [CNT_W-1:0]  o_out_col,
   output logic              o_done
);

   localparam int OUT_W = IN_W - K + 1;
   localparam logic [CNT_W-1:0]  K_LAST   = CNT_W'(K - 1);
   localparam logic [CNT_W-1:0]  OUT_LAST = CNT_W'(OUT_W - 1);
   localparam logic [ADDR_W-1:0] ROW_PITCH = ADDR_W'(IN_W);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  kc, kr, kc_nxt, kr_nxt;
   logic [CNT_W-1:0]  oc_nxt, or_nxt;
   logic [ADDR_W-1:0] addr_nxt;
   logic              valid_nxt, first_nxt, last_nxt, busy_nxt, done_nxt;
   logic              stall;
   logic              tap_final;

`ifdef CONV_SEQ_STALL_EN
   assign stall = i_stall;
`else
   assign stall = 1'b0;
`endif

   // The counters always hold the tap most recently presented, so reaching
   // the final tap means it has already been issued.
   assign tap_final = (kc == K_LAST) && (kr == K_LAST) &&
                      (o_out_col == OUT_LAST) && (o_out_row == OUT_LAST);

   // Next-state, next-counter and next-output decode; outputs are registered.
   always_comb begin
      state_nxt = state;
      kc_nxt    = kc;
      kr_nxt    = kr;
      oc_nxt    = o_out_col;
      or_nxt    = o_out_row;
      addr_nxt  = o_rd_addr;
      valid_nxt = 1'b0;
      first_nxt = 1'b0;
      last_nxt  = 1'b0;
      busy_nxt  = 1'b0;
      done_nxt  = 1'b0;
      case (state)
         S_IDLE: begin
            if (i_start) begin
               state_nxt = S_RUN;
               kc_nxt    = '0;
               kr_nxt    = '0;
               oc_nxt    = '0;
               or_nxt    = '0;
               addr_nxt  = '0;
               valid_nxt = 1'b1;
               first_nxt = 1'b1;
               last_nxt  = (K_LAST == '0);
               busy_nxt  = 1'b1;
            end
         end
         S_RUN: begin
            busy_nxt = 1'b1;
            if (tap_final) begin
               // A stall here is ignored: the run is already complete.
               state_nxt = S_DONE;
               busy_nxt  = 1'b0;
               done_nxt  = 1'b1;
            end else if (!stall) begin
               if (kc == K_LAST) begin
                  kc_nxt = '0;
                  if (kr == K_LAST) begin
                     kr_nxt = '0;
                     if (o_out_col == OUT_LAST) begin
                        oc_nxt = '0;
                        or_nxt = o_out_row + 1'b1;
                     end else begin
                        oc_nxt = o_out_col + 1'b1;
                     end
                  end else begin
                     kr_nxt = kr + 1'b1;
                  end
               end else begin
                  kc_nxt = kc + 1'b1;
               end
               addr_nxt  = (ADDR_W'(or_nxt) + ADDR_W'(kr_nxt)) * ROW_PITCH +
                           ADDR_W'(oc_nxt) + ADDR_W'(kc_nxt);
               valid_nxt = 1'b1;
               first_nxt = (kc_nxt == '0) && (kr_nxt == '0);
               last_nxt  = (kc_nxt == K_LAST) && (kr_nxt == K_LAST);
            end
            // Stalled: counters and address hold, markers drop for a cycle.
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // State, counter and output registers with asynchronous clear.
   always_ff @(posedge clk or negedge global_rst_n) begin
      if (!global_rst_n) begin
         state       <= S_IDLE;
         kc          <= '0;
         kr          <= '0;
         o_out_col   <= '0;
         o_out_row   <= '0;
         o_rd_addr   <= '0;
         o_rd_valid  <= 1'b0;
         o_win_first <= 1'b0;
         o_win_last  <= 1'b0;
         o_busy      <= 1'b0;
         o_done      <= 1'b0;
      end else begin
         state       <= state_nxt;
         kc          <= kc_nxt;
         kr          <= kr_nxt;
         o_out_col   <= oc_nxt;
         o_out_row   <= or_nxt;
         o_rd_addr   <= addr_nxt;
         o_rd_valid  <= valid_nxt;
         o_win_first <= first_nxt;
         o_win_last  <= last_nxt;
         o_busy      <= busy_nxt;
         o_done      <= done_nxt;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_conv_window_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_window_sequencer
// Description : Self-checking bench for conv_window_sequencer. A small
//               (IN_W=6, K=3) instance is checked cycle by cycle against a
//               nested-loop tap list; a default-parameter instance is checked
//               over one full run. Stall cases build with CONV_SEQ_STALL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_window_sequencer;

   localparam int SI = 6;
   localparam int SK = 3;
   localparam int SO = SI - SK + 1;
   localparam int DI = 32;
   localparam int DK = 5;
   localparam int DO = DI - DK + 1;

   typedef struct packed {
      logic [9:0] addr;
      logic       first;
      logic       last;
      logic [5:0] row;
      logic [5:0] col;
   } tap_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       start = 1'b0;
   logic       stall = 1'b0;
   logic       start_d = 1'b0;

   logic       s_busy, s_valid, s_first, s_last, s_done;
   logic [9:0] s_addr;
   logic [5:0] s_row, s_col;
   logic       d_busy, d_valid, d_first, d_last, d_done;
   logic [9:0] d_addr;
   logic [5:0] d_row, d_col;

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   conv_window_sequencer #(.IN_W(SI), .K(SK), .CNT_W(6), .ADDR_W(10)) dut_s (
      .clk         (clk),
      .global_rst_n(rst_n),
      .i_start     (start),
`ifdef CONV_SEQ_STALL_EN
      .i_stall     (stall),
`endif
      .o_busy      (s_busy),
      .o_rd_addr   (s_addr),
      .o_rd_valid  (s_valid),
      .o_win_first (s_first),
      .o_win_last  (s_last),
      .o_out_row   (s_row),
      .o_out_col   (s_col),
      .o_done      (s_done)
   );

   conv_window_sequencer dut_d (
      .clk         (clk),
      .global_rst_n(rst_n),
      .i_start     (start_d),
`ifdef CONV_SEQ_STALL_EN
      .i_stall     (1'b0),
`endif
      .o_busy      (d_busy),
      .o_rd_addr   (d_addr),
      .o_rd_valid  (d_valid),
      .o_win_first (d_first),
      .o_win_last  (d_last),
      .o_out_row   (d_row),
      .o_out_col   (d_col),
      .o_done      (d_done)
   );

   // Packed view: {valid, first, last, busy, done, addr, row, col}
   function automatic logic [31:0] mk(input logic v, input logic f, input logic l,
                                      input logic b, input logic d, input logic [9:0] a,
                                      input logic [5:0] r, input logic [5:0] c);
      return {5'b0, v, f, l, b, d, a, r, c};
   endfunction

   function automatic logic [31:0] obs_s();
      return mk(s_valid, s_first, s_last, s_busy, s_done, s_addr, s_row, s_col);
   endfunction

   function automatic logic [31:0] obs_d();
      return mk(d_valid, d_first, d_last, d_busy, d_done, d_addr, d_row, d_col);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One run on the small instance, checked against a nested-loop tap list.
   // stall_mode: 0 none, 1 three cycles after the fifth tap, 2 random.
   // Entered and left at 1 ns after a rising edge while the DUT is idle.
   task automatic do_run(input bit hold, input int stall_mode);
      tap_t q[$];
      tap_t cur;
      tap_t prev;
      int   idx = 0;
      int   cyc = 1;
      int   bubbles = 0;
      int   n_first = 0;
      int   n_last = 0;
      int   left = 0;
      bit   armed = 0;
      bit   prev_stall = 0;
      logic [31:0] exp;
      for (int r = 0; r < SO; r++)
         for (int c = 0; c < SO; c++)
            for (int kr = 0; kr < SK; kr++)
               for (int kc = 0; kc < SK; kc++) begin
                  cur.addr  = 10'((r + kr) * SI + c + kc);
                  cur.first = (kr == 0) && (kc == 0);
                  cur.last  = (kr == SK - 1) && (kc == SK - 1);
                  cur.row   = 6'(r);
                  cur.col   = 6'(c);
                  q.push_back(cur);
               end
      prev = '0;
      start = 1'b1;
      tick();
      if (!hold) start = 1'b0;
      while (idx < q.size() && cyc < 2000) begin
         if (prev_stall) begin
            exp = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, prev.addr, prev.row, prev.col);
            bubbles++;
         end else begin
            cur  = q[idx];
            exp  = mk(1'b1, cur.first, cur.last, 1'b1, 1'b0, cur.addr, cur.row, cur.col);
            prev = cur;
            idx++;
         end
         check(prev_stall ? "bubble" : "tap", obs_s(), exp);
         if (s_first) n_first++;
         if (s_last)  n_last++;
         stall = 1'b0;
         if (stall_mode == 1) begin
            if (idx == 5 && !prev_stall && !armed) begin
               left  = 3;
               armed = 1;
            end
            stall = (left > 0);
            if (left > 0) left--;
         end else if (stall_mode == 2) begin
            stall = ($urandom_range(0, 3) == 0);
         end
         prev_stall = stall;
         tick();
         cyc++;
      end
      check("run_complete", 32'(idx), 32'(q.size()));
      check("done_cycle", 32'(cyc), 32'(SO * SO * SK * SK + bubbles + 1));
      if (stall_mode == 1) check("done_cycle_stall", 32'(cyc), 32'd148);
      check("done_ctrl", {27'b0, s_valid, s_first, s_last, s_busy, s_done}, 32'b00001);
      check("first_count", 32'(n_first), 32'(SO * SO));
      check("last_count", 32'(n_last), 32'(SO * SO));
      stall = 1'b0;
      tick();
      check("idle_ctrl", {27'b0, s_valid, s_first, s_last, s_busy, s_done}, 32'b00000);
   endtask

   // Reset asserted at cycle 'at' of a run; outputs must clear at once.
   task automatic reset_test(input int at);
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (at - 1) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("rst_async_s", obs_s(), 32'b0);
      repeat (3) begin
         tick();
         check("rst_hold_s", obs_s(), 32'b0);
      end
      rst_n = 1'b1;
      tick();
      check("rst_release_s", obs_s(), 32'b0);
      do_run(1'b0, 0);
   endtask

   task automatic idle_gap();
      int n;
      n = $urandom_range(0, 4);
      repeat (n) begin
         tick();
         check("gap_idle", {27'b0, s_valid, s_first, s_last, s_busy, s_done}, 32'b0);
      end
   endtask

   initial begin
      logic [9:0] last_addr;
      logic [5:0] last_row, last_col;
      logic       last_flag;
      int         n_valid;
      #1 rst_n = 1'b0;
      #1;
      check("reset_s", obs_s(), 32'b0);
      check("reset_d", obs_d(), 32'b0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      check("post_reset_idle", obs_s(), 32'b0);

      do_run(1'b0, 0);
      idle_gap();
      do_run(1'b1, 0);
      do_run(1'b0, 0);
      idle_gap();
      reset_test(50);
      idle_gap();
      reset_test($urandom_range(2, 140));
`ifdef CONV_SEQ_STALL_EN
      idle_gap();
      do_run(1'b0, 1);
      idle_gap();
      do_run(1'b0, 2);
      do_run(1'b0, 2);
`endif

      // Full default-parameter run.
      n_valid   = 0;
      last_addr = '0;
      last_row  = '0;
      last_col  = '0;
      last_flag = 1'b0;
      start_d = 1'b1;
      tick();
      start_d = 1'b0;
      for (int r = 0; r < DO; r++)
         for (int c = 0; c < DO; c++)
            for (int kr = 0; kr < DK; kr++)
               for (int kc = 0; kc < DK; kc++) begin
                  check("dflt_tap", obs_d(),
                        mk(1'b1, (kr == 0) && (kc == 0), (kr == DK - 1) && (kc == DK - 1),
                           1'b1, 1'b0, 10'((r + kr) * DI + c + kc), 6'(r), 6'(c)));
                  if (d_valid) n_valid++;
                  last_addr = d_addr;
                  last_row  = d_row;
                  last_col  = d_col;
                  last_flag = d_last;
                  tick();
               end
      check("dflt_valid_count", 32'(n_valid), 32'd19600);
      check("dflt_final_tap", {16'b0, last_flag, last_addr, last_row[4:0]},
            {16'b0, 1'b1, 10'd1023, 5'd27});
      check("dflt_final_col", 32'(last_col), 32'd27);
      check("dflt_done", {27'b0, d_valid, d_first, d_last, d_busy, d_done}, 32'b00001);
      tick();
      check("dflt_idle", {27'b0, d_valid, d_first, d_last, d_busy, d_done}, 32'b00000);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
